m68k_bus_decoder: RTL and testbench



---
 rtl/armedf_bus_pkg.sv | 59 +++++
 rtl/m68k_bus_decoder_region_match.sv | 28 ++
 rtl/m68k_bus_decoder.sv | 147 ++++++++++++++
 tb/tb_m68k_bus_decoder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/armedf_bus_pkg.sv
// Shared definitions for the 68000/Z80 bus decoder: FSM state encoding,
// region entry layout and the per-PCB default maps the boot loader writes.
package armedf_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ACK  = 3'd2,
        ST_MISS = 3'd3,
        ST_BERR = 3'd4
    } bus_state_t;

    // Field layout of one table entry as seen by the loader (68000 side widths).
    localparam int PCB_ADDR_W  = 24;
    localparam int PCB_WAIT_W  = 4;
    localparam int PCB_REGIONS = 4;

    typedef struct packed {
        logic                  en;
        logic [PCB_ADDR_W-1:0] rstart;
        logic [PCB_ADDR_W-1:0] rend;
        logic [PCB_WAIT_W-1:0] rwait;
    } region_t;

    typedef region_t pcb_map_t [PCB_REGIONS];

    // Default maps: program ROM, work RAM, video/palette RAM, I/O.
    localparam pcb_map_t TERRAF_MAP = '{
        '{1'b1, 24'h000000, 24'h04FFFF, 4'd0},
        '{1'b1, 24'h060000, 24'h0603FF, 4'd0},
        '{1'b1, 24'h064000, 24'h064FFF, 4'd1},
        '{1'b1, 24'h07C000, 24'h07C00F, 4'd2}
    };
    localparam pcb_map_t ARMEDF_MAP = '{
        '{1'b1, 24'h000000, 24'h05FFFF, 4'd0},
        '{1'b1, 24'h060000, 24'h063FFF, 4'd0},
        '{1'b1, 24'h068000, 24'h069FFF, 4'd1},
        '{1'b1, 24'h06C000, 24'h06C00F, 4'd2}
    };
    localparam pcb_map_t LEGIONJB_MAP = '{
        '{1'b1, 24'h000000, 24'h04FFFF, 4'd0},
        '{1'b1, 24'h060000, 24'h063FFF, 4'd0},
        '{1'b1, 24'h074000, 24'h074FFF, 4'd1},
        '{1'b1, 24'h07C000, 24'h07C00F, 4'd2}
    };
    localparam pcb_map_t KOZURE_MAP = '{
        '{1'b1, 24'h000000, 24'h05FFFF, 4'd0},
        '{1'b1, 24'h060000, 24'h063FFF, 4'd0},
        '{1'b1, 24'h068000, 24'h069FFF, 4'd1},
        '{1'b1, 24'h07C000, 24'h07C00F, 4'd2}
    };
    localparam pcb_map_t BIGFGHTR_MAP = '{
        '{1'b1, 24'h000000, 24'h07FFFF, 4'd0},
        '{1'b1, 24'h080000, 24'h0805FF, 4'd0},
        '{1'b1, 24'h08D000, 24'h08DFFF, 4'd1},
        '{1'b1, 24'h08E000, 24'h08E00F, 4'd2}
    };

endpackage

// File: rtl/m68k_bus_decoder_region_match.sv
// Combinational region lookup: all entries compared in parallel, lowest
// matching index wins. Entries with start > end can never match.
module region_match #(
    parameter int N_REGIONS = 16,
    parameter int ADDR_W    = 24,
    parameter int IDX_W     = 4
) (
    input  logic [ADDR_W-1:0]                 addr,
    input  logic [N_REGIONS-1:0]              en,
    input  logic [N_REGIONS-1:0][ADDR_W-1:0]  rstart,
    input  logic [N_REGIONS-1:0][ADDR_W-1:0]  rend,
    output logic                              hit,
    output logic [IDX_W-1:0]                  idx
);

    // Scan high-to-low so the last assignment is the lowest matching index.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (en[i] && (addr >= rstart[i]) && (addr <= rend[i])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/m68k_bus_decoder.sv
// Run-time programmable bus decoder: region table, registered one-hot chip
// selects, DTACK with per-region wait states and bus-error timeout.
module m68k_bus_decoder
    import armedf_bus_pkg::*;
#(
    parameter int N_REGIONS   = 16,
    parameter int ADDR_W      = 24,
    parameter int WAIT_W      = 4,
    parameter int TIMEOUT_CYC = 64,
    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1,
    localparam int TO_W  = $clog2(TIMEOUT_CYC),
    localparam int CNT_W = (WAIT_W > TO_W) ? WAIT_W : TO_W
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic                 cfg_en,
    input  logic [ADDR_W-1:0]    cfg_start,
    input  logic [ADDR_W-1:0]    cfg_end,
    input  logic [WAIT_W-1:0]    cfg_wait,
    input  logic [ADDR_W-1:0]    m68k_a,
    input  logic                 m68k_as_n,
    output logic [N_REGIONS-1:0] cs_vec,
    output logic [IDX_W-1:0]     hit_idx,
    output logic                 dtack_n,
    output logic                 berr_n,
    output logic                 busy
);

    logic [N_REGIONS-1:0]             en_q;
    logic [N_REGIONS-1:0][ADDR_W-1:0] start_q;
    logic [N_REGIONS-1:0][ADDR_W-1:0] end_q;
    logic [N_REGIONS-1:0][WAIT_W-1:0] wait_q;

    bus_state_t           state_q;
    logic                 as_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [N_REGIONS-1:0] cs_vec_q;
    logic [IDX_W-1:0]     hit_idx_q;
    logic                 dtack_n_q;
    logic                 berr_n_q;

    logic                 match_hit;
    logic [IDX_W-1:0]     match_idx;

    // Region table; cleared on reset so the loader must reprogram it.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            en_q    <= '0;
            start_q <= '0;
            end_q   <= '0;
            wait_q  <= '0;
        end else if (cfg_we && (int'(cfg_idx) < N_REGIONS)) begin
            en_q[cfg_idx]    <= cfg_en;
            start_q[cfg_idx] <= cfg_start;
            end_q[cfg_idx]   <= cfg_end;
            wait_q[cfg_idx]  <= cfg_wait;
        end
    end

    region_match #(
        .N_REGIONS (N_REGIONS),
        .ADDR_W    (ADDR_W),
        .IDX_W     (IDX_W)
    ) u_match (
        .addr   (m68k_a),
        .en     (en_q),
        .rstart (start_q),
        .rend   (end_q),
        .hit    (match_hit),
        .idx    (match_idx)
    );

    // Bus-cycle FSM; the address is looked at only on the AS falling edge,
    // and every output is a register so selects are glitch-free.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            as_q      <= 1'b0;
            cnt_q     <= '0;
            cs_vec_q  <= '0;
            hit_idx_q <= '0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
        end else begin
            as_q <= m68k_as_n;
            case (state_q)
                ST_IDLE: begin
                    if (as_q && !m68k_as_n) begin
                        if (match_hit) begin
                            cs_vec_q  <= N_REGIONS'(1) << match_idx;
                            hit_idx_q <= match_idx;
                            cnt_q     <= CNT_W'(wait_q[match_idx]);
                            state_q   <= ST_WAIT;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_MISS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (m68k_as_n) begin
                        cs_vec_q <= '0;
                        state_q  <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        dtack_n_q <= 1'b0;
                        state_q   <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    if (m68k_as_n) begin
                        cs_vec_q  <= '0;
                        dtack_n_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_MISS: begin
                    if (m68k_as_n) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        berr_n_q <= 1'b0;
                        state_q  <= ST_BERR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_BERR: begin
                    if (m68k_as_n) begin
                        berr_n_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cs_vec  = cs_vec_q;
    assign hit_idx = hit_idx_q;
    assign dtack_n = dtack_n_q;
    assign berr_n  = berr_n_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_m68k_bus_decoder.sv
// Scoreboard bench: each bus cycle's outcome is predicted from the region
// table rules and queued; a monitor measures what the decoder does per cycle.
module tb_m68k_bus_decoder;

    localparam int N  = 16;
    localparam int TO = 64;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        cfg_we  = 1'b0;
    logic [3:0]  cfg_idx = '0;
    logic        cfg_en  = 1'b0;
    logic [23:0] cfg_start = '0;
    logic [23:0] cfg_end   = '0;
    logic [3:0]  cfg_wait  = '0;
    logic [23:0] m68k_a    = '0;
    logic        m68k_as_n = 1'b1;
    logic [15:0] cs_vec;
    logic [3:0]  hit_idx;
    logic        dtack_n, berr_n, busy;

    always #5 clk_sys = ~clk_sys;

    m68k_bus_decoder #(.N_REGIONS(N), .ADDR_W(24), .WAIT_W(4), .TIMEOUT_CYC(TO)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_en    (cfg_en),
        .cfg_start (cfg_start),
        .cfg_end   (cfg_end),
        .cfg_wait  (cfg_wait),
        .m68k_a    (m68k_a),
        .m68k_as_n (m68k_as_n),
        .cs_vec    (cs_vec),
        .hit_idx   (hit_idx),
        .dtack_n   (dtack_n),
        .berr_n    (berr_n),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference table
    bit          m_en [N];
    int unsigned m_lo [N];
    int unsigned m_hi [N];
    int          m_wt [N];

    // Expected per-cycle outcome: selected region (-1 none), DTACK and BERR
    // latency in clocks after the select appears (-1 never), cycle length.
    typedef struct {
        int cs_bit;
        int dlat;
        int blat;
        int blen;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // AS held low for h edges starting at the decode edge.
    function automatic exp_t predict(input int unsigned a, input int h);
        exp_t e;
        e.cs_bit = -1;
        for (int i = 0; i < N; i++) begin
            if (m_en[i] && m_lo[i] <= a && a <= m_hi[i]) begin
                e.cs_bit = i;
                break;
            end
        end
        e.blen = h;
        if (e.cs_bit >= 0) begin
            e.blat = -1;
            e.dlat = (h >= m_wt[e.cs_bit] + 2) ? m_wt[e.cs_bit] + 1 : -1;
        end else begin
            e.dlat = -1;
            e.blat = (h >= TO + 1) ? TO : -1;
        end
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) m_en[i] = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input bit en, input int unsigned lo,
                             input int unsigned hi, input int wt);
        @(posedge clk_sys);
        #1;
        cfg_we    = 1'b1;
        cfg_idx   = 4'(idx);
        cfg_en    = en;
        cfg_start = 24'(lo);
        cfg_end   = 24'(hi);
        cfg_wait  = 4'(wt);
        @(posedge clk_sys);
        #1;
        cfg_we = 1'b0;
        m_en[idx] = en;
        m_lo[idx] = lo;
        m_hi[idx] = hi;
        m_wt[idx] = wt;
    endtask

    // One bus cycle; the address is scrambled after decode, which must be ignored.
    task automatic bus_cycle(input int unsigned a, input int h, input int gap);
        exp_t e;
        e = predict(a, h);
        sb.push_back(e);
        @(posedge clk_sys);
        #1;
        m68k_a    = 24'(a);
        m68k_as_n = 1'b0;
        @(posedge clk_sys);
        #1;
        m68k_a = 24'($urandom);
        repeat (h - 1) @(posedge clk_sys);
        #1;
        m68k_as_n = 1'b1;
        repeat (gap) @(posedge clk_sys);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk_sys);
        if (sb.size() != 0) chk("drain_pending", sb.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cs_vec"},  cs_vec,  0);
        chk({tag, "_hit_idx"}, hit_idx, 0);
        chk({tag, "_dtack_n"}, dtack_n, 1);
        chk({tag, "_berr_n"},  berr_n,  1);
        chk({tag, "_busy"},    busy,    0);
    endtask

    // Monitor
    bit          in_cyc = 1'b0;
    int          n, dl, bl;
    logic [15:0] cs0;
    logic [3:0]  idx0;

    always @(negedge clk_sys) begin
        exp_t e;
        chk("dtack_berr_excl", (!dtack_n && !berr_n), 0);
        chk("cs_onehot", ($countones(cs_vec) <= 1), 1);
        if (reset) begin
            in_cyc = 1'b0;
        end else begin
            if (in_cyc) n++;
            if (!in_cyc && busy) begin
                in_cyc = 1'b1;
                n      = 0;
                cs0    = cs_vec;
                idx0   = hit_idx;
                dl     = -1;
                bl     = -1;
            end
            if (in_cyc) begin
                if (busy) begin
                    if (!dtack_n && dl < 0) dl = n;
                    if (!berr_n && bl < 0)  bl = n;
                end else begin
                    in_cyc = 1'b0;
                    if (sb.size() == 0) begin
                        chk("unexpected_cycle", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("cs_vec", cs0, (e.cs_bit < 0) ? 0 : (1 << e.cs_bit));
                        if (e.cs_bit >= 0) chk("hit_idx", idx0, e.cs_bit);
                        chk("dtack_latency", dl, e.dlat);
                        chk("berr_latency",  bl, e.blat);
                        chk("busy_length",   n,  e.blen);
                        chk("end_cs_vec",    cs_vec,  0);
                        chk("end_dtack_n",   dtack_n, 1);
                        chk("end_berr_n",    berr_n,  1);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        int unsigned lo, hi, a, tmp;
        int          h, k;

        clear_model();
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        @(negedge clk_sys);
        chk_reset_vals("reset");

        // Basic hit, wait 0
        cfg_write(0, 1, 'h060000, 'h063FFF, 0);
        bus_cycle('h060010, 4, 0);
        // Wait 5, back-to-back follow-up
        cfg_write(3, 1, 'h06C000, 'h06C001, 5);
        bus_cycle('h06C000, 10, 0);
        bus_cycle('h06C001, 7, 0);
        bus_cycle('h06C002, 3, 1);
        // Overlap priority, then lower entry disabled
        cfg_write(1, 1, 'h000000, 'h0FFFFF, 2);
        cfg_write(7, 1, 'h078000, 'h078007, 1);
        bus_cycle('h078004, 6, 0);
        cfg_write(1, 0, 'h000000, 'h0FFFFF, 2);
        bus_cycle('h078004, 6, 0);
        // Unmapped: full timeout, then an early release
        bus_cycle('h0F0000, 70, 0);
        bus_cycle('h0F0000, 10, 0);
        bus_cycle('h0F0000, TO, 0);
        bus_cycle('h0F0000, TO + 1, 0);
        // Table rewrite while a wait-5 cycle is in flight
        fork
            bus_cycle('h06C000, 10, 0);
            begin
                repeat (2) @(posedge clk_sys);
                cfg_write(0, 1, 'h080000, 'h0805FF, 0);
            end
        join
        bus_cycle('h080000, 4, 0);
        bus_cycle('h060010, 4, 0);
        drain();

        // Reset in WAIT with AS held low
        @(posedge clk_sys);
        #1;
        m68k_a    = 24'h06C000;
        m68k_as_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b1;
        @(posedge clk_sys);
        #1 reset = 1'b0;
        clear_model();
        @(negedge clk_sys);
        chk_reset_vals("midreset");
        repeat (5) begin
            @(negedge clk_sys);
            chk("no_decode_after_reset", busy, 0);
        end
        @(posedge clk_sys);
        #1 m68k_as_n = 1'b1;
        bus_cycle('h06C000, 3, 0);
        cfg_write(3, 1, 'h06C000, 'h06C001, 5);
        bus_cycle('h06C001, 9, 0);
        drain();

        // Randomized tables and accesses
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                lo = $urandom_range(0, 'hFB0000);
                hi = lo + $urandom_range(0, 'h3FFFF);
                if ($urandom_range(0, 7) == 0 && hi != lo) begin
                    tmp = lo; lo = hi; hi = tmp;
                end
                cfg_write(i, ($urandom_range(0, 3) != 0), lo, hi, $urandom_range(0, 15));
            end
            for (int t = 0; t < 80; t++) begin
                k = $urandom_range(0, N - 1);
                if ($urandom_range(0, 1) == 0 && m_lo[k] <= m_hi[k])
                    a = m_lo[k] + $urandom_range(0, m_hi[k] - m_lo[k]);
                else
                    a = $urandom_range(0, 'hFFFFFF);
                h = ($urandom_range(0, 19) == 0) ? $urandom_range(TO, TO + 4)
                                                 : $urandom_range(1, 20);
                bus_cycle(a, h, $urandom_range(0, 2));
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
